// File: rtl/edge_bins_grid.sv
// edge_bins_grid: Avalon-ST pass-through slice that counts horizontal intensity edges into
// column bins per frame and commits them to an Avalon-MM readable shadow bank at eop.
module edge_bins_grid #(
  parameter int IMAGE_W   = 640,
  parameter int IMAGE_H   = 480,
  parameter int NUM_BINS  = 20,
  parameter int CNT_W     = 20,
  parameter int THR_RESET = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic        sink_ready,
  output logic [23:0] source_data,
  output logic        source_valid,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        source_ready,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata
);
  localparam int BIN_W = IMAGE_W / NUM_BINS;
  localparam int NPIX = IMAGE_W * IMAGE_H;
  localparam int PW = $clog2(NPIX + 1);
  localparam int XW = $clog2(IMAGE_W + 1);
  localparam int IW = NUM_BINS > 1 ? $clog2(NUM_BINS) : 1;
  localparam logic [PW-1:0] NPIX_L = PW'(NPIX);
  localparam logic [PW-1:0] LAST_L = PW'(NPIX - 1);
  localparam logic [XW-1:0] XMAX = XW'(IMAGE_W - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [31:0] A_THR = 32'(NUM_BINS);
  localparam logic [31:0] A_CTRL = 32'(NUM_BINS + 1);
  localparam logic [31:0] A_STAT = 32'(NUM_BINS + 2);

  logic active, s1_v, s1_eop, size_err;
  logic [PW-1:0] pcnt;
  logic [XW-1:0] x, s1_x, bin;
  logic [7:0] thr, thr_l, s1_y, prev_y;
  logic [2:0] ctrl;
  logic [1:0] mode_l;
  logic [15:0] frame_cnt;
  logic [CNT_W-1:0] live [NUM_BINS];
  logic [CNT_W-1:0] shadow [NUM_BINS];
  logic [CNT_W-1:0] nxt [NUM_BINS];
  logic [9:0] ysum;
  logic [8:0] yn, yp;
  logic [31:0] rd;
  logic acc, sop_acc, pix_acc, in_range, restart, size_set, rise, fall, hit, we, unused;

  assign sink_ready = source_ready || !source_valid;
  assign acc = sink_valid && sink_ready;
  assign sop_acc = acc && sink_sop;
  assign pix_acc = acc && !sink_sop && active;
  assign in_range = pcnt < NPIX_L;
  assign restart = sop_acc && active;
  assign size_set = restart || (pix_acc && (!in_range || (sink_eop && pcnt != LAST_L)));
  assign ysum = {2'b0, sink_data[23:16]} + {1'b0, sink_data[15:8], 1'b0} + {2'b0, sink_data[7:0]};
  assign yn = {1'b0, s1_y};
  assign yp = {1'b0, prev_y};
  assign rise = s1_x != '0 && yn > yp + {1'b0, thr_l};
  assign fall = s1_x != '0 && yp > yn + {1'b0, thr_l};
  assign hit = s1_v && (mode_l == 2'd0 ? rise || fall : mode_l == 2'd1 ? rise : mode_l == 2'd2 ? fall : 1'b0);
  assign bin = s1_x / XW'(BIN_W);
  assign we = s_chipselect && s_write;
  assign rd = s_address < A_THR ? 32'(shadow[s_address[IW-1:0]]) :
              s_address == A_THR ? {24'b0, thr} :
              s_address == A_CTRL ? {29'b0, ctrl} :
              s_address == A_STAT ? {15'b0, size_err, frame_cnt} : '0;
  assign unused = ^{s_writedata[31:17], s_writedata[15:8], ysum[1:0]};

  always_comb
    for (int b = 0; b < NUM_BINS; b++)
      nxt[b] = (hit && bin == XW'(b) && live[b] != CMAX) ? live[b] + 1'b1 : live[b];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      source_data <= '0;
      source_valid <= 1'b0;
      source_sop <= 1'b0;
      source_eop <= 1'b0;
    end else if (acc) begin
      source_data <= sink_data;
      source_valid <= 1'b1;
      source_sop <= sink_sop;
      source_eop <= sink_eop;
    end else if (source_ready) begin
      source_valid <= 1'b0;
    end

  // Parse and stage 1: header latches thr/mode so mid-frame writes wait for the next frame.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      active <= 1'b0;
      pcnt <= '0;
      x <= '0;
      thr_l <= 8'(THR_RESET);
      mode_l <= '0;
      s1_v <= 1'b0;
      s1_eop <= 1'b0;
      s1_y <= '0;
      s1_x <= '0;
      prev_y <= '0;
    end else begin
      if (sop_acc) begin
        active <= sink_data[3:0] == 4'd0 && ctrl[0] && !sink_eop;
        pcnt <= '0;
        x <= '0;
        if (sink_data[3:0] == 4'd0) {thr_l, mode_l} <= {thr, ctrl[2:1]};
      end else if (pix_acc) begin
        if (sink_eop) active <= 1'b0;
        if (in_range) begin
          pcnt <= pcnt + 1'b1;
          x <= x == XMAX ? '0 : x + 1'b1;
        end
      end
      s1_v <= pix_acc && in_range;
      s1_eop <= pix_acc && sink_eop;
      s1_y <= ysum[9:2];
      s1_x <= x;
      if (s1_v) prev_y <= s1_y;
    end

  // Stage 2 and register file; the eop tag commits the pixel's own increment with the bank.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        live[b] <= '0;
        shadow[b] <= '0;
      end
      frame_cnt <= '0;
      size_err <= 1'b0;
      thr <= 8'(THR_RESET);
      ctrl <= 3'b001;
      s_readdata <= '0;
    end else begin
      for (int b = 0; b < NUM_BINS; b++) begin
        live[b] <= (restart || s1_eop) ? '0 : nxt[b];
        if (s1_eop) shadow[b] <= nxt[b];
      end
      if (s1_eop) frame_cnt <= frame_cnt + 1'b1;
      size_err <= size_set ? 1'b1 : (we && s_address == A_STAT && s_writedata[16]) ? 1'b0 : size_err;
      if (we && s_address == A_THR) thr <= s_writedata[7:0];
      if (we && s_address == A_CTRL) ctrl <= s_writedata[2:0];
      s_readdata <= (s_chipselect && s_read) ? rd : '0;
    end
endmodule

// File: tb/tb_edge_bins_grid.sv
// tb_edge_bins_grid: directed frames on a reduced 32x20 image with 4 bins and 5-bit counters.
module tb_edge_bins_grid;
  localparam int W = 32, H = 20, NB = 4, CW = 5, NPIX = W * H;
  localparam int A_THR = NB, A_CTRL = NB + 1, A_STAT = NB + 2;

  logic clk = 0, reset_n = 0;
  logic [23:0] sink_data = '0, source_data;
  logic sink_valid = 0, sink_sop = 0, sink_eop = 0, sink_ready;
  logic source_valid, source_sop, source_eop, source_ready = 1;
  logic s_chipselect = 0, s_read = 0, s_write = 0;
  logic [31:0] s_address = '0, s_writedata = '0, s_readdata;
  logic [25:0] exp_q[$];
  logic [31:0] v;
  bit rnd_en = 0;
  int total = 0, bad = 0;

  edge_bins_grid #(.IMAGE_W(W), .IMAGE_H(H), .NUM_BINS(NB), .CNT_W(CW), .THR_RESET(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
    .source_eop(source_eop), .source_ready(source_ready),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2 source_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (reset_n && source_valid && source_ready) begin
      if (exp_q.size() == 0) chk("stray_beat", exp_q.size(), 1);
      else chk("stream", {6'b0, source_sop, source_eop, source_data}, 32'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic [23:0] d, input bit s, input bit e);
    bit rdy;
    sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      #1 rdy = sink_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back({s, e, d});
        #1 sink_valid = 0;
        return;
      end
    end
    chk("ready_timeout", 32'(sink_ready), 1);
    sink_valid = 0;
  endtask

  task automatic pixels(input int from, input int to, input int eop_at);
    for (int i = from; i < to; i++) begin
      int px = i % W;
      send((px == 7 || px == 8 || px == 30) ? 24'h0000FF : 24'h0, 0, i == eop_at);
    end
  endtask

  task automatic full_frame();
    send(24'h0, 1, 0);
    pixels(0, NPIX, NPIX - 1);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    s_chipselect = 1; s_write = 1; s_address = 32'(a); s_writedata = d;
    @(posedge clk);
    #1 s_write = 0; s_chipselect = 0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    s_chipselect = 1; s_read = 1; s_address = 32'(a);
    @(posedge clk);
    #1 s_read = 0; s_chipselect = 0;
    d = s_readdata;
  endtask

  task automatic chk_bins(input string tag, input int e0, input int e1, input int e2, input int e3,
                          input logic [31:0] st);
    int e[4];
    logic [31:0] r;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) begin
      rd(i, r);
      chk($sformatf("%s_bin%0d", tag, i), r, 32'(e[i]));
    end
    rd(A_STAT, r);
    chk({tag, "_status"}, r, st);
  endtask

  initial begin
    #12;
    chk("rst_sink_ready", 32'(sink_ready), 1);
    chk("rst_source_valid", {source_valid, source_sop, source_eop, source_data}, 0);
    #11 reset_n = 1;
    @(posedge clk);
    #1;
    rd(A_THR, v);  chk("rst_thr", v, 32);
    rd(A_CTRL, v); chk("rst_ctrl", v, 1);
    rd(A_STAT, v); chk("rst_status", v, 0);
    rd(0, v);      chk("rst_bin0", v, 0);

    // mode 0, thr 32; bin3 collects 40 edges and saturates at 31
    full_frame();
    rd(0, v); chk("commit_cycle_old", v, 0);
    rd(0, v); chk("commit_visible", v, 20);
    chk_bins("mode0", 20, 20, 0, 31, 32'h1);

    wr(A_CTRL, 3); full_frame(); chk_bins("mode1", 20, 0, 0, 20, 32'h2);
    wr(A_CTRL, 5); full_frame(); chk_bins("mode2", 0, 20, 0, 20, 32'h3);
    wr(A_CTRL, 1);
    wr(A_THR, 63); full_frame(); chk_bins("thr63", 0, 0, 0, 0, 32'h4);
    wr(A_THR, 62); full_frame(); chk_bins("thr62", 20, 20, 0, 31, 32'h5);

    // thr write mid-frame only affects the following frame
    send(24'h0, 1, 0);
    pixels(0, 100, -1);
    wr(A_THR, 63);
    pixels(100, NPIX, NPIX - 1);
    chk_bins("mid_old_thr", 20, 20, 0, 31, 32'h6);
    full_frame(); chk_bins("mid_new_thr", 0, 0, 0, 0, 32'h7);

    wr(A_THR, 32);
    rnd_en = 1;
    full_frame();
    rnd_en = 0;
    chk_bins("backpressure", 20, 20, 0, 31, 32'h8);

    send(24'h0, 1, 0);
    pixels(0, 100, 99);
    chk_bins("short", 3, 3, 0, 6, 32'h10009);
    wr(A_STAT, 32'h10000);
    rd(A_STAT, v); chk("size_err_clear", v, 32'h9);

    send(24'h00000F, 1, 0);
    pixels(0, NPIX, NPIX - 1);
    chk_bins("type_f", 3, 3, 0, 6, 32'h9);

    send(24'h0, 1, 0);
    pixels(0, 50, -1);
    full_frame();
    chk_bins("restart", 20, 20, 0, 31, 32'h1000A);
    wr(A_STAT, 32'h10000);

    send(24'h0, 1, 0);
    pixels(0, NPIX + 5, NPIX + 4);
    chk_bins("excess", 20, 20, 0, 31, 32'h1000B);

    send(24'h0, 1, 0);
    pixels(0, 200, -1);
    wr(A_THR, 7);
    reset_n = 0;
    #2;
    chk("async_rst_valid", 32'(source_valid), 0);
    exp_q.delete();
    #5 reset_n = 1;
    @(posedge clk);
    #1;
    rd(A_THR, v);  chk("mrst_thr", v, 32);
    rd(A_CTRL, v); chk("mrst_ctrl", v, 1);
    rd(A_STAT, v); chk("mrst_status", v, 0);
    rd(3, v);      chk("mrst_bin3", v, 0);
    full_frame(); chk_bins("after_rst", 20, 20, 0, 31, 32'h1);

    wr(A_CTRL, 0);
    full_frame();
    chk_bins("disabled", 20, 20, 0, 31, 32'h1);

    repeat (5) @(posedge clk);
    #1 chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/edge_bins_grid.md
# edge_bins_grid

Parametrised successor to the column edge-binning stage in the camera vision pipeline. It sits inline on the 24-bit RGB Avalon-ST video stream and forwards every beat through a one-deep register slice. It detects horizontal intensity edges with a programmable threshold and polarity mode, and counts them into NUM_BINS column bins per frame. At each end of packet it commits the counts to a shadow bank that the Nios reads over an Avalon-MM slave.

## Interface
Parameters:
- IMAGE_W, 640, active pixels per row; must be divisible by NUM_BINS
- IMAGE_H, 480, rows per frame
- NUM_BINS, 20, number of column bins; BIN_W = IMAGE_W/NUM_BINS
- CNT_W, 20, bin counter width; counters saturate at 2^CNT_W-1
- THR_RESET, 32, reset value of the threshold register

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sink_data  in  24  pixel, R[23:16] G[15:8] B[7:0]
- sink_valid, sink_sop, sink_eop  in  1  Avalon-ST sink qualifiers
- sink_ready  out  1  sink backpressure
- source_data  out  24  forwarded pixel
- source_valid, source_sop, source_eop  out  1  forwarded qualifiers
- source_ready  in  1  downstream backpressure
- s_chipselect, s_read, s_write  in  1  Avalon-MM controls
- s_address  in  32  word address
- s_writedata  in  32  write data
- s_readdata  out  32  read data, 1-cycle latency

One clock (clk). reset_n is asynchronous and active-low.

## Operation
- A beat is accepted when sink_valid && sink_ready.
- Pass-through: a one-entry register slice. sink_ready = source_ready || !source_valid. Data and qualifiers are unmodified.
- Packet parse: the sop beat is a header. Processing happens only if sink_data[3:0]==0; other packet types pass through uncounted. Beats after the header are pixels, indexed by x (0..IMAGE_W-1) and y, with x wrapping into y. The eop beat is counted as a pixel if its index is < IMAGE_W*IMAGE_H.
- Intensity: Y = (R + 2G + B) >> 2, computed 10 bits wide and truncated to 8 bits.
- Edge: for x>0 only, with d = Y(x) − Y(x−1) as a signed 9-bit value.
  - Rising edge: d > thr.
  - Falling edge: −d > thr.
  - No comparison across row boundaries.
- Mode selects which edges are counted:
  - 0: rising or falling
  - 1: rising only
  - 2: falling only
  - 3: none
- Bin index = x / BIN_W. The counter for that bin increments by 1 and saturates.
- thr and mode are latched at each accepted type-0 sop. Register writes made mid-frame take effect at the next frame.
- Commit: when the eop pixel leaves the pipeline:
  - shadow[b] = live[b] + that pixel's increment;
  - all live counters clear;
  - frame_cnt increments (16-bit wrap).
- size_err (sticky) sets in either case:
  - eop arrives with pixel count ≠ IMAGE_W*IMAGE_H;
  - more than IMAGE_W*IMAGE_H pixels arrive (the excess is ignored).
  The frame still commits.
- A sop arriving without a prior eop discards the live counts and restarts at x=y=0. It sets size_err and does not commit.
- If ctrl.enable=0, nothing is counted or committed and the stream still passes.
- Register map (word addresses); unmapped addresses read 0 and ignore writes:
  - 0..NUM_BINS−1: shadow bin counts, RO, zero-extended.
  - NUM_BINS: threshold [7:0], RW, reset THR_RESET.
  - NUM_BINS+1: ctrl, RW, reset 0x1. Bit 0 = enable, bits [2:1] = mode.
  - NUM_BINS+2: status. Bits [15:0] = frame_cnt (RO). Bit 16 = size_err; writing 1 clears it.

## Timing
- Reset values: source_valid/sop/eop=0, source_data=0, s_readdata=0, all live and shadow counters=0, frame_cnt=0, size_err=0, thr=THR_RESET, ctrl=0x1. sink_ready=1 after reset.
- Stream latency: 1 cycle, with no bubbles under continuous source_ready. A stalled beat holds source_* stable.
- Pixel pipeline has 2 stages:
  - stage 1 registers Y, x and the eop tag;
  - stage 2 compares and updates the counter.
- The shadow commit is visible to reads starting 3 cycles after eop acceptance.
- The earliest pixel of the next frame is accepted 2 beats after eop (header in between). No counts are lost or mixed between frames.
- s_readdata is registered: the value for an address presented in cycle n appears in cycle n+1. Reading the shadow during a commit cycle returns the pre-commit value.
- Simultaneous write-1-to-clear of size_err and a new size error: the set wins.
- Asserting reset_n low mid-frame clears everything immediately. The first frame after reset must start with a sop.

## Test plan
- Frame 640x480 (header, 307200 pixels, eop on the last pixel); sink_data=0x0000FF at x∈{31,32,630}, else 0; thr=32, mode 0 -> bin0=480, bin1=480, bin19=960, all other bins 0, frame_cnt=1, size_err=0.
- Same frame with mode 1 -> bin0=480, bin19=480, others 0. Mode 2 -> bin1=480, bin19=480.
- Same frame with thr=63 -> all bins 0 (d=63 is not >63). thr=62 -> same result as the first scenario.
- Threshold written mid-frame -> the current frame uses the old thr and the next frame uses the new one. source_ready toggled randomly -> identical counts, and the output beat stream equals the input stream.
- Frame with eop after 1000 pixels -> commits, size_err=1. Writing 0x10000 to status -> size_err=0. Header with type 0xF -> no counting and no commit.
- reset_n pulsed low mid-frame -> all registers are at reset values. The next full frame gives the first-scenario result with frame_cnt=1.
